pre_i_buf_ctrl: RTL and testbench

Ping-pong controller for the pre-intra 8x8 pixel buffer built from two 32-bit x 16-word two-port RAMs (bank 0, bank 1; 1-cycle registered read). It accepts one 8x8 block (16 words, 4 pixels/word) at a time from the pixel fetch stage and streams completed blocks to the pre-intra mode-decision engine. Write and read proceed concurrently on opposite banks. The block drives the RAM ports directly and muxes the RAM read data.

---
 rtl/pre_i_buf_ctrl.sv | 143 ++++++++++++++
 tb/tb_pre_i_buf_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_i_buf_ctrl.sv
// Ping-pong controller for the pre-intra 8x8 pixel buffer.
// Two 16-word banks: the writer fills one bank while the reader streams the other.
// Drives both RAM ports directly and muxes the registered RAM read data.
module pre_i_buf_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    input  logic        rd_start,
    output logic        rd_avail,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [3:0]  rd_idx,
    output logic        rd_last,
    output logic [1:0]  full_cnt,
    output logic [1:0]  ram_we,
    output logic [3:0]  ram_waddr,
    output logic [31:0] ram_wdata,
    output logic [1:0]  ram_rd,
    output logic [3:0]  ram_raddr,
    input  logic [31:0] ram0_rdata,
    input  logic [31:0] ram1_rdata
);

    typedef enum logic [0:0] {StIdle, StRead} rd_state_e;

    logic [1:0] full_q, full_d;
    logic       wbank_q, wbank_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       rbank_q, rbank_d;
    logic [3:0] rcnt_q, rcnt_d;
    rd_state_e  state_q, state_d;
    logic       rd_valid_q;
    logic [3:0] rd_idx_q;
    logic       rd_sel_q;

    logic wr_acc;
    logic wr_done;
    logic rd_done;

    // Write side: accept into the current bank while it is empty, flip banks after word 15.
    always_comb begin
        wr_ready  = ~full_q[wbank_q] & ~clr;
        wr_acc    = wr_valid & wr_ready;
        wr_done   = wr_acc & (wcnt_q == 4'd15);
        ram_we    = 2'b00;
        if (wr_acc) begin
            ram_we[wbank_q] = 1'b1;
        end
        ram_waddr = wcnt_q;
        ram_wdata = wr_data;
        wcnt_d    = wr_acc ? wcnt_q + 4'd1 : wcnt_q;
        wbank_d   = wr_done ? ~wbank_q : wbank_q;
    end

    // Reader FSM: wait for a full bank, then issue 16 consecutive reads from it.
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        rbank_d   = rbank_q;
        rd_avail  = 1'b0;
        ram_rd    = 2'b00;
        ram_raddr = rcnt_q;
        rd_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                rd_avail = full_q[rbank_q];
                if (rd_start && full_q[rbank_q]) begin
                    state_d = StRead;
                    rcnt_d  = 4'd0;
                end
            end
            StRead: begin
                ram_rd[rbank_q] = 1'b1;
                rcnt_d          = rcnt_q + 4'd1;
                if (rcnt_q == 4'd15) begin
                    rd_done = 1'b1;
                    rbank_d = ~rbank_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Full flags: writer sets, reader clears on issuing word 15; both may happen together.
    always_comb begin
        full_d = full_q;
        if (wr_done) begin
            full_d[wbank_q] = 1'b1;
        end
        if (rd_done) begin
            full_d[rbank_q] = 1'b0;
        end
    end

    // State registers; clr returns everything to reset values and drops in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= 2'b00;
            wbank_q    <= 1'b0;
            wcnt_q     <= 4'd0;
            rbank_q    <= 1'b0;
            rcnt_q     <= 4'd0;
            state_q    <= StIdle;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= 4'd0;
            rd_sel_q   <= 1'b0;
        end else if (clr) begin
            full_q     <= 2'b00;
            wbank_q    <= 1'b0;
            wcnt_q     <= 4'd0;
            rbank_q    <= 1'b0;
            rcnt_q     <= 4'd0;
            state_q    <= StIdle;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= 4'd0;
            rd_sel_q   <= 1'b0;
        end else begin
            full_q     <= full_d;
            wbank_q    <= wbank_d;
            wcnt_q     <= wcnt_d;
            rbank_q    <= rbank_d;
            rcnt_q     <= rcnt_d;
            state_q    <= state_d;
            rd_valid_q <= |ram_rd;
            rd_idx_q   <= ram_raddr;
            rd_sel_q   <= rbank_q;
        end
    end

    // Output side: RAM data is already registered, so only the bank select is tracked.
    always_comb begin
        rd_valid = rd_valid_q;
        rd_idx   = rd_idx_q;
        rd_data  = rd_sel_q ? ram1_rdata : ram0_rdata;
        rd_last  = rd_valid_q & (rd_idx_q == 4'd15);
        full_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    end

endmodule

// File: tb/tb_pre_i_buf_ctrl.sv
// Bench for pre_i_buf_ctrl: two RAM models, a block-queue reference model and
// a per-cycle compare process, plus directed literal checks.
module tb_pre_i_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_ready;
    logic        rd_start = 1'b0;
    logic        rd_avail;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [3:0]  rd_idx;
    logic        rd_last;
    logic [1:0]  full_cnt;
    logic [1:0]  ram_we;
    logic [3:0]  ram_waddr;
    logic [31:0] ram_wdata;
    logic [1:0]  ram_rd;
    logic [3:0]  ram_raddr;
    logic [31:0] ram0_rdata;
    logic [31:0] ram1_rdata;

    int vectors = 0;
    int miscompares = 0;

    pre_i_buf_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_start   (rd_start),
        .rd_avail   (rd_avail),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_idx     (rd_idx),
        .rd_last    (rd_last),
        .full_cnt   (full_cnt),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_rd     (ram_rd),
        .ram_raddr  (ram_raddr),
        .ram0_rdata (ram0_rdata),
        .ram1_rdata (ram1_rdata)
    );

    always #5 clk = ~clk;

    // Two-port RAMs with registered read, read-before-write on address collision.
    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];
    always @(posedge clk) begin
        if (ram_rd[0]) ram0_rdata <= mem0[ram_raddr];
        if (ram_rd[1]) ram1_rdata <= mem1[ram_raddr];
        if (ram_we[0]) mem0[ram_waddr] <= ram_wdata;
        if (ram_we[1]) mem1[ram_waddr] <= ram_wdata;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endfunction

    // Reference model: completed blocks sit in a word queue (16 words each) until the
    // reader has issued their last word; blocks alternate banks starting at bank 0.
    logic [31:0] fullq [$];
    logic [31:0] part [16];
    int          m_pcnt = 0;
    bit          m_wpar = 0;
    bit          m_rpar = 0;
    bit          m_busy = 0;
    int          m_k = 0;
    bit          exp_v = 0;
    int          exp_idx = 0;
    logic [31:0] exp_data = 32'd0;

    task automatic m_reset();
        fullq.delete();
        m_pcnt = 0;
        m_wpar = 0;
        m_rpar = 0;
        m_busy = 0;
        m_k = 0;
        exp_v = 0;
        exp_idx = 0;
    endtask

    task automatic m_step();
        int nf;
        bit acc;
        bit st;
        nf  = fullq.size() / 16;
        acc = wr_valid && (nf < 2) && !clr;
        st  = rd_start && !m_busy && (nf > 0);
        if (clr) begin
            m_reset();
        end else begin
            if (m_busy) begin
                exp_v    = 1;
                exp_idx  = m_k;
                exp_data = fullq[m_k];
                if (m_k == 15) begin
                    repeat (16) void'(fullq.pop_front());
                    m_busy = 0;
                    m_rpar = !m_rpar;
                end else begin
                    m_k++;
                end
            end else begin
                exp_v = 0;
            end
            if (acc) begin
                part[m_pcnt] = wr_data;
                if (m_pcnt == 15) begin
                    for (int i = 0; i < 16; i++) fullq.push_back(part[i]);
                    m_pcnt = 0;
                    m_wpar = !m_wpar;
                end else begin
                    m_pcnt++;
                end
            end
            if (st) begin
                m_busy = 1;
                m_k = 0;
            end
        end
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // Every cycle out of reset, all outputs are checked against the model.
    task automatic compare();
        int nf;
        bit e_ready;
        logic [1:0] e_we;
        logic [1:0] e_rd;
        nf      = fullq.size() / 16;
        e_ready = (nf < 2) && !clr;
        e_we    = (wr_valid && e_ready) ? (m_wpar ? 2'b10 : 2'b01) : 2'b00;
        e_rd    = m_busy ? (m_rpar ? 2'b10 : 2'b01) : 2'b00;
        chk("wr_ready", 32'(wr_ready), 32'(e_ready));
        chk("full_cnt", 32'(full_cnt), nf);
        chk("rd_avail", 32'(rd_avail), 32'(!m_busy && nf > 0));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        if (e_we != 2'b00) begin
            chk("ram_waddr", 32'(ram_waddr), m_pcnt);
            chk("ram_wdata", ram_wdata, wr_data);
        end
        chk("ram_rd", 32'(ram_rd), 32'(e_rd));
        if (m_busy) chk("ram_raddr", 32'(ram_raddr), m_k);
        chk("rd_valid", 32'(rd_valid), 32'(exp_v));
        chk("rd_last", 32'(rd_last), 32'(exp_v && exp_idx == 15));
        if (exp_v) begin
            chk("rd_idx", 32'(rd_idx), exp_idx);
            chk("rd_data", rd_data, exp_data);
        end
    endtask

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (!rst) compare();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = ($urandom % 10) < 7;
            wr_data  = $urandom;
            rd_start = ($urandom % 10) < 3;
            clr      = ($urandom % 300) == 0;
            tick();
        end
        wr_valid = 0;
        rd_start = 0;
        clr = 0;
    endtask

    initial begin : stim
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_avail", 32'(rd_avail), 32'd0);
        chk("rst_full_cnt", 32'(full_cnt), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_rd", 32'(ram_rd), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        tick();

        // One block of k*0x01010101, then stream it back
        for (int k = 0; k < 16; k++) begin
            wr_valid = 1;
            wr_data  = k * 32'h01010101;
            tick();
        end
        wr_valid = 0;
        @(negedge clk);
        chk("blk1_full_cnt", 32'(full_cnt), 32'd1);
        chk("blk1_rd_avail", 32'(rd_avail), 32'd1);
        rd_start = 1;
        tick();
        rd_start = 0;
        @(negedge clk);
        chk("blk1_ram_rd", 32'(ram_rd), 32'b01);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("blk1_rd_valid", 32'(rd_valid), 32'd1);
            chk("blk1_rd_idx", 32'(rd_idx), k);
            chk("blk1_rd_data", rd_data, k * 32'h01010101);
            chk("blk1_rd_last", 32'(rd_last), 32'(k == 15));
            if (k == 15) begin
                chk("blk1_full_cnt_end", 32'(full_cnt), 32'd0);
                chk("blk1_rd_avail_end", 32'(rd_avail), 32'd0);
            end
        end
        tick();

        // clr during a read with the other bank partially written
        for (int k = 0; k < 16; k++) begin
            wr_valid = 1;
            wr_data  = $urandom;
            tick();
        end
        rd_start = 1;
        wr_data  = $urandom;
        tick();
        rd_start = 0;
        repeat (6) begin
            wr_data = $urandom;
            tick();
        end
        clr = 1;
        @(negedge clk);
        chk("clr_wr_ready", 32'(wr_ready), 32'd0);
        chk("clr_ram_we", 32'(ram_we), 32'd0);
        tick();
        clr = 0;
        wr_valid = 0;
        @(negedge clk);
        chk("clr_rd_valid1", 32'(rd_valid), 32'd0);
        chk("clr_full_cnt", 32'(full_cnt), 32'd0);
        chk("clr_wr_ready_after", 32'(wr_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("clr_rd_valid2", 32'(rd_valid), 32'd0);
        tick();
        wr_valid = 1;
        wr_data  = $urandom;
        @(negedge clk);
        chk("clr_ram_we_bank0", 32'(ram_we), 32'b01);
        chk("clr_ram_waddr0", 32'(ram_waddr), 32'd0);

        // Fill both banks, hold wr_valid, then free one bank by reading
        for (int i = 1; i < 32; i++) begin
            tick();
            wr_data = $urandom;
        end
        tick();
        repeat (3) begin
            @(negedge clk);
            chk("both_wr_ready", 32'(wr_ready), 32'd0);
            chk("both_ram_we", 32'(ram_we), 32'd0);
            chk("both_full_cnt", 32'(full_cnt), 32'd2);
            tick();
        end
        rd_start = 1;
        tick();
        rd_start = 0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("both_wr_ready_T16", 32'(wr_ready), 32'd0);
        @(negedge clk);
        chk("both_wr_ready_T17", 32'(wr_ready), 32'd1);
        repeat (16) begin
            tick();
            wr_data = $urandom;
        end
        wr_valid = 0;
        rd_start = 1;
        repeat (60) tick();
        rd_start = 0;

        // Random traffic against the model
        rand_phase(3000);

        // rd_start during a partial write, then async reset mid-read
        clr = 1;
        tick();
        clr = 0;
        for (int k = 0; k < 7; k++) begin
            wr_valid = 1;
            wr_data  = $urandom;
            tick();
        end
        wr_valid = 0;
        rd_start = 1;
        tick();
        rd_start = 0;
        @(negedge clk);
        chk("part_ram_rd", 32'(ram_rd), 32'd0);
        chk("part_rd_avail", 32'(rd_avail), 32'd0);
        tick();
        @(negedge clk);
        chk("part_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        for (int k = 0; k < 9; k++) begin
            wr_valid = 1;
            wr_data  = $urandom;
            tick();
        end
        wr_valid = 0;
        rd_start = 1;
        tick();
        rd_start = 0;
        repeat (4) tick();
        #2 rst = 1;
        #1;
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_ram_rd", 32'(ram_rd), 32'd0);
        chk("arst_full_cnt", 32'(full_cnt), 32'd0);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        chk("arst_rd_avail", 32'(rd_avail), 32'd0);
        chk("arst_rd_last", 32'(rd_last), 32'd0);
        #2 rst = 0;
        tick();
        rand_phase(1000);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
